mulacc32_seq: RTL and testbench

- Iterative 32x32 multiply-accumulate computing p = a*b + c (64-bit). It is the inverse of the restoring divider datapath: it rebuilds a dividend from quotient, divisor and remainder (x = q*d + r).
- Consumes STEP_BITS multiplier bits per cycle, LSB-first, with valid/ready handshakes on both input and output.
- Sits beside the divider units and serves as the reconstruction/check path for division results.

---
 rtl/mulacc_pkg.sv | 9 +
 rtl/mulacc_digit.sv | 12 +
 rtl/mulacc32_seq.sv | 79 +++++++
 tb/tb_mulacc32_seq.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mulacc_pkg.sv
// mulacc_pkg: shared states, widths and STEP_BITS legality check for mulacc32_seq
package mulacc_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int W  = 32;
   localparam int PW = 64;
   function automatic bit step_ok(input int s);
      return s == 1 || s == 2 || s == 4 || s == 8;
   endfunction
endpackage

// File: rtl/mulacc_digit.sv
// mulacc_digit: STEP_BITS x 64 partial product of one multiplier digit and the shifted multiplicand
module mulacc_digit
   import mulacc_pkg::*;
#(
   parameter int STEP_BITS = 4
) (
   input  logic [STEP_BITS-1:0] digit,
   input  logic [PW-1:0]        mcand,
   output logic [PW-1:0]        pp
);
   assign pp = mcand * PW'(digit);
endmodule

// File: rtl/mulacc32_seq.sv
// mulacc32_seq: iterative p = a*b + c, STEP_BITS multiplier bits per cycle, LSB-first.
// Optional MULACC_EARLY_EXIT_EN ends BUSY once the remaining multiplier bits are all zero.
module mulacc32_seq
   import mulacc_pkg::*;
#(
   parameter int STEP_BITS = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [W-1:0]  c,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] p
);
   localparam int NSTEPS = W / STEP_BITS;
   localparam logic [5:0] LAST = 6'(NSTEPS - 1);
   if (!step_ok(STEP_BITS)) begin : g_bad_step
      $error("mulacc32_seq: STEP_BITS must be 1, 2, 4 or 8");
   end
   state_t state, state_n;
   logic [PW-1:0] acc, mcand, pp, acc_n;
   logic [W-1:0] mplier, mplier_n;
   logic [5:0] count;
   logic last;
   mulacc_digit #(.STEP_BITS(STEP_BITS)) u_digit (
      .digit(mplier[STEP_BITS-1:0]),
      .mcand(mcand),
      .pp(pp)
   );
   assign acc_n    = acc + pp;
   assign mplier_n = mplier >> STEP_BITS;
   assign in_ready = state == IDLE;
   always_comb begin
      last = count == LAST;
`ifdef MULACC_EARLY_EXIT_EN
      last = last || mplier_n == '0;
`endif
      state_n = (state == IDLE && in_valid)  ? BUSY :
                (state == BUSY && last)      ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         p         <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         count     <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: if (in_valid) begin
               mplier <= a;
               mcand  <= PW'(b);
               acc    <= PW'(c);
               count  <= '0;
            end
            BUSY: begin
               acc    <= acc_n;
               mcand  <= mcand << STEP_BITS;
               mplier <= mplier_n;
               count  <= count + 6'd1;
               if (last) begin
                  p         <= acc_n;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mulacc32_seq.sv
// tb_mulacc32_seq: directed and random checks of mulacc32_seq at STEP_BITS 4, 1 and 8 against an arithmetic model
module tb_mulacc32_seq;
   logic clk = 1'b0;
   logic rstn;
   logic [31:0] a, b, c;
   logic ivq [3];
   logic orq [3];
   logic irq [3];
   logic ovq [3];
   logic [63:0] pq [3];
   int cmp = 0;
   int errs = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int SB = (g == 0) ? 4 : (g == 1) ? 1 : 8;
      mulacc32_seq #(.STEP_BITS(SB)) dut (
         .clk(clk), .rstn(rstn), .in_valid(ivq[g]), .in_ready(irq[g]),
         .a(a), .b(b), .c(c), .out_valid(ovq[g]), .out_ready(orq[g]), .p(pq[g])
      );
   end
   function automatic int sbof(input int k);
      return (k == 0) ? 4 : (k == 1) ? 1 : 8;
   endfunction
   function automatic logic [63:0] model(input logic [31:0] x, y, z);
      return {32'b0, x} * {32'b0, y} + {32'b0, z};
   endfunction
   function automatic int exp_lat(input int sb, input logic [31:0] x);
`ifdef MULACC_EARLY_EXIT_EN
      int m = 0;
      for (int i = 0; i < 32; i++) if (x[i]) m = i + 1;
      return (m == 0) ? 1 : (m + sb - 1) / sb;
`else
      return 32 / sb;
`endif
   endfunction
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      cmp++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic wait_out(input int k, output int lat);
      lat = 0;
      while (ovq[k] !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask
   task automatic handshake(input int k, input string tag);
      @(negedge clk) orq[k] = 1'b1;
      @(posedge clk); #1;
      orq[k] = 1'b0;
      check({tag, " ov_drop"}, 64'(ovq[k]), 64'd0);
      check({tag, " ir_back"}, 64'(irq[k]), 64'd1);
   endtask
   task automatic do_op(input int k, input logic [31:0] ta, tb, tc, input string tag);
      int lat;
      @(negedge clk);
      a = ta; b = tb; c = tc; ivq[k] = 1'b1;
      @(posedge clk); #1;
      ivq[k] = 1'b0;
      check({tag, " ir_busy"}, 64'(irq[k]), 64'd0);
      wait_out(k, lat);
      check({tag, " lat"}, 64'(lat), 64'(exp_lat(sbof(k), ta)));
      check({tag, " p"}, pq[k], model(ta, tb, tc));
      handshake(k, tag);
   endtask
   initial begin
      logic [31:0] ra, rb, rc, a2;
      logic [63:0] e1;
      int lat;
      rstn = 1'b0;
      a = '0; b = '0; c = '0;
      for (int k = 0; k < 3; k++) begin ivq[k] = 1'b0; orq[k] = 1'b0; end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("rst p", pq[k], 64'd0);
         check("rst ov", 64'(ovq[k]), 64'd0);
         check("rst ir", 64'(irq[k]), 64'd1);
      end
      rstn = 1'b1;
      do_op(0, 32'd3, 32'd5, 32'd7, "small");
      check("small const", pq[0], 64'h16);
      do_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "max");
      check("max const", pq[0], 64'hFFFFFFFF00000000);
      do_op(0, 32'hFFFFFFFF, 32'd2, 32'd0, "x2");
      check("x2 const", pq[0], 64'h00000001FFFFFFFE);
      for (int k = 0; k < 3; k++) begin
         do_op(k, 32'h00010000, 32'h00010000, 32'd1, "pow16");
         check("pow16 const", pq[k], 64'h0000000100000001);
      end
      do_op(0, 32'd1, 32'h1234, 32'd0, "one");
      check("one const", pq[0], 64'h1234);
      do_op(0, 32'd0, 32'hDEADBEEF, 32'h55, "zero_a");
      // Backpressure: new operands offered while the result is parked must wait for the handshake.
      @(negedge clk);
      a = 32'h12345678; b = 32'h9ABCDEF0; c = 32'h0F0F0F0F; ivq[0] = 1'b1;
      e1 = model(a, b, c);
      @(posedge clk); #1;
      a2 = 32'h00C0FFEE;
      a = a2; b = 32'd77; c = 32'd5;
      wait_out(0, lat);
      repeat (5) begin
         @(posedge clk); #1;
         check("bp p", pq[0], e1);
         check("bp ov", 64'(ovq[0]), 64'd1);
         check("bp ir", 64'(irq[0]), 64'd0);
      end
      handshake(0, "bp");
      @(posedge clk); #1;
      ivq[0] = 1'b0;
      check("bp accept2", 64'(irq[0]), 64'd0);
      wait_out(0, lat);
      check("bp lat2", 64'(lat), 64'(exp_lat(4, a2)));
      check("bp p2", pq[0], model(a2, 32'd77, 32'd5));
      handshake(0, "bp2");
      // Reset during BUSY must abort with no output.
      @(negedge clk);
      a = 32'hFFFF0000; b = 32'h11111111; c = 32'd9; ivq[0] = 1'b1;
      @(posedge clk); #1;
      ivq[0] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      check("midrst ov", 64'(ovq[0]), 64'd0);
      check("midrst p", pq[0], 64'd0);
      check("midrst ir", 64'(irq[0]), 64'd1);
      repeat (10) @(posedge clk);
      #1;
      check("midrst quiet", 64'(ovq[0]), 64'd0);
      do_op(0, 32'd2, 32'd3, 32'd0, "after_rst");
      check("after_rst const", pq[0], 64'd6);
      for (int i = 0; i < 24; i++) begin
         ra = $urandom >> $urandom_range(0, 31);
         rb = $urandom;
         rc = $urandom;
         do_op(i % 3, ra, rb, rc, "rand");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
